rns_fwd_conv_seq: RTL and testbench

- Binary-to-RNS forward converter. Accepts a signed 64-bit two's-complement integer and produces the 8-digit, 18-bit residue word consumed by the normalization pipeline and the residue arithmetic units.
- This is the encoder end of the residue digit interface. Its outputs drive the Dig_0..Dig_7 style inputs downstream.
- Iterative design: all digits run a Horner recurrence in parallel, 4 bits per clock.

---
 rtl/rns_pkg.sv | 26 ++
 rtl/rns_horner_step.sv | 30 +++
 rtl/rns_fwd_conv_seq.sv | 131 +++++++++++++
 tb/tb_rns_fwd_conv_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared types and default moduli for the 8-digit residue number system datapath.
package rns_pkg;

  localparam int unsigned DIGIT_W    = 18;
  localparam int unsigned NUM_DIGITS = 8;

  localparam int unsigned MOD_DEF_0 = 131072;  // 2^17
  localparam int unsigned MOD_DEF_1 = 78125;   // 5^7
  localparam int unsigned MOD_DEF_2 = 177147;  // 3^11
  localparam int unsigned MOD_DEF_3 = 117649;  // 7^6
  localparam int unsigned MOD_DEF_4 = 161051;  // 11^5
  localparam int unsigned MOD_DEF_5 = 28561;   // 13^4
  localparam int unsigned MOD_DEF_6 = 83521;   // 17^4
  localparam int unsigned MOD_DEF_7 = 130321;  // 19^4

  typedef logic [DIGIT_W-1:0] rns_digit_t;
  typedef rns_digit_t [NUM_DIGITS-1:0] rns_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/rns_horner_step.sv
// One Horner step: (16*r + nibble) mod Mod, reduced by a fixed subtraction chain.
module rns_horner_step
  import rns_pkg::*;
#(
  parameter int unsigned Mod = MOD_DEF_0
) (
  input  logic [DIGIT_W-1:0] r_i,
  input  logic [3:0]         nibble_i,
  output logic [DIGIT_W-1:0] r_o
);

  localparam int unsigned AccW = DIGIT_W + 4;

  localparam logic [AccW-1:0] M8 = AccW'(Mod * 8);
  localparam logic [AccW-1:0] M4 = AccW'(Mod * 4);
  localparam logic [AccW-1:0] M2 = AccW'(Mod * 2);
  localparam logic [AccW-1:0] M1 = AccW'(Mod);

  logic [AccW-1:0] acc0, acc1, acc2, acc3;

  // r_i < Mod bounds acc0 below 16*Mod, so each stage halves the remaining range.
  always_comb begin
    acc0 = {r_i, nibble_i};
    acc1 = (acc0 >= M8) ? acc0 - M8 : acc0;
    acc2 = (acc1 >= M4) ? acc1 - M4 : acc1;
    acc3 = (acc2 >= M2) ? acc2 - M2 : acc2;
    r_o  = (acc3 >= M1) ? DIGIT_W'(acc3 - M1) : DIGIT_W'(acc3);
  end

endmodule

// File: rtl/rns_fwd_conv_seq.sv
// Sequential binary-to-RNS forward converter: signed 64-bit in, 8 residue digits out,
// 4 bits per clock across all digits in parallel.
module rns_fwd_conv_seq
  import rns_pkg::*;
#(
  parameter int unsigned MOD_0 = MOD_DEF_0,
  parameter int unsigned MOD_1 = MOD_DEF_1,
  parameter int unsigned MOD_2 = MOD_DEF_2,
  parameter int unsigned MOD_3 = MOD_DEF_3,
  parameter int unsigned MOD_4 = MOD_DEF_4,
  parameter int unsigned MOD_5 = MOD_DEF_5,
  parameter int unsigned MOD_6 = MOD_DEF_6,
  parameter int unsigned MOD_7 = MOD_DEF_7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] dig_0,
  output logic [DIGIT_W-1:0] dig_1,
  output logic [DIGIT_W-1:0] dig_2,
  output logic [DIGIT_W-1:0] dig_3,
  output logic [DIGIT_W-1:0] dig_4,
  output logic [DIGIT_W-1:0] dig_5,
  output logic [DIGIT_W-1:0] dig_6,
  output logic [DIGIT_W-1:0] dig_7,
  output logic               out_neg
);

  localparam int unsigned MODS [NUM_DIGITS] = '{MOD_0, MOD_1, MOD_2, MOD_3,
                                                MOD_4, MOD_5, MOD_6, MOD_7};

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [63:0] mag_q, mag_d;
  logic [3:0]  cnt_q, cnt_d;
  rns_word_t   r_q, r_d;
  rns_word_t   dig_q, dig_d;
  logic        neg_q, neg_d;
  rns_word_t   step;

  // Magnitude is shifted left each CONV cycle, so the top nibble is always the next one.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_step
    rns_horner_step #(
      .Mod(MODS[g])
    ) u_step (
      .r_i     (r_q[g]),
      .nibble_i(mag_q[63:60]),
      .r_o     (step[g])
    );
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    dig_d   = dig_q;
    neg_d   = neg_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d  = in_data[63];
          // -2^63 negates to 2^63, which is representable as unsigned.
          mag_d   = in_data[63] ? (64'd0 - in_data) : in_data;
          r_d     = '0;
          cnt_d   = 4'd15;
          state_d = StConv;
        end
      end
      StConv: begin
        r_d   = step;
        mag_d = {mag_q[59:0], 4'h0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = StFix;
        end
      end
      StFix: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          dig_d[i] = (sign_q && (r_q[i] != '0)) ? rns_digit_t'(MODS[i]) - r_q[i] : r_q[i];
        end
        neg_d   = sign_q;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      dig_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      dig_q   <= dig_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_neg   = neg_q;
  assign dig_0     = dig_q[0];
  assign dig_1     = dig_q[1];
  assign dig_2     = dig_q[2];
  assign dig_3     = dig_q[3];
  assign dig_4     = dig_q[4];
  assign dig_5     = dig_q[5];
  assign dig_6     = dig_q[6];
  assign dig_7     = dig_q[7];

endmodule

// File: tb/tb_rns_fwd_conv_seq.sv
// Scoreboard bench for rns_fwd_conv_seq: directed corner cases plus a randomized stream
// checked against a plain modular-arithmetic reference.
module tb_rns_fwd_conv_seq;

  localparam int unsigned NRand = 2000;
  localparam logic [63:0] M [8] = '{64'd131072, 64'd78125, 64'd177147, 64'd117649,
                                    64'd161051, 64'd28561, 64'd83521, 64'd130321};

  typedef struct packed {
    logic             neg;
    logic [7:0][17:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready, out_valid, out_neg;
  logic [17:0] dig [8];

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  rns_fwd_conv_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dig_0    (dig[0]),
    .dig_1    (dig[1]),
    .dig_2    (dig[2]),
    .dig_3    (dig[3]),
    .dig_4    (dig[4]),
    .dig_5    (dig[5]),
    .dig_6    (dig[6]),
    .dig_7    (dig[7]),
    .out_neg  (out_neg)
  );

  // x mod m for signed x, taken into [0, m-1].
  function automatic exp_t model(input logic [63:0] x);
    exp_t        e;
    logic [63:0] mag, r;
    mag   = x[63] ? (~x + 64'd1) : x;
    e.neg = x[63];
    for (int i = 0; i < 8; i++) begin
      r = mag % M[i];
      if (x[63] && r != 64'd0) r = M[i] - r;
      e.d[i] = r[17:0];
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] x);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back(model(x));
      #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(3) != 0);
  end

  always @(negedge clk) begin
    exp_t got, exp;
    if (rst_n && out_valid && out_ready) begin
      got.neg = out_neg;
      for (int i = 0; i < 8; i++) got.d[i] = dig[i];
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%h expected=none", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL residue_word actual=%h expected=%h", got, exp);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [17:0] snap [8];
    logic [63:0] x;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dig0", 64'(dig[0]), 64'd0);
    chk("rst_out_neg", 64'(out_neg), 64'd0);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;

    send(64'd0);
    wait_valid(n);
    for (int i = 0; i < 8; i++) chk("zero_dig", 64'(dig[i]), 64'd0);
    chk("zero_neg", 64'(out_neg), 64'd0);
    tick();
    chk("zero_in_ready_after_hs", 64'(in_ready), 64'd1);

    send(64'd1);
    wait_valid(n);
    chk("one_latency", 64'(n), 64'd17);
    for (int i = 0; i < 8; i++) chk("one_dig", 64'(dig[i]), 64'd1);
    tick();

    send(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(n);
    chk("m1_dig0", 64'(dig[0]), 64'h1FFFF);
    chk("m1_dig1", 64'(dig[1]), 64'h1312C);
    chk("m1_dig5", 64'(dig[5]), 64'd28560);
    chk("m1_neg", 64'(out_neg), 64'd1);
    tick();

    send(64'h1122_10F4_7DE9_8115);
    wait_valid(n);
    chk("big_dig0", 64'(dig[0]), 64'h18115);
    tick();

    send(64'h8000_0000_0000_0000);
    wait_valid(n);
    chk("minint_dig0", 64'(dig[0]), 64'd0);
    chk("minint_neg", 64'(out_neg), 64'd1);
    tick();

    // Backpressure: output held, new requests ignored.
    out_ready = 1'b0;
    send(64'hF00D_CAFE_1234_5678);
    wait_valid(n);
    for (int i = 0; i < 8; i++) snap[i] = dig[i];
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      tick();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 8; i++) chk("bp_dig_stable", 64'(dig[i]), 64'(snap[i]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    chk("bp_out_valid_after", 64'(out_valid), 64'd0);
    repeat (20) tick();
    chk("bp_no_extra_output", 64'(out_valid), 64'd0);

    // Reset during conversion drops the word in flight.
    send(64'h0BAD_BEEF_0000_1111);
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) chk("midrst_dig", 64'(dig[i]), 64'd0);
    chk("midrst_neg", 64'(out_neg), 64'd0);
    sb.delete(sb.size() - 1);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_hold_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(64'hFFFF_FFFF_8765_4321);
    wait_valid(n);
    tick();

    rand_ready = 1'b1;
    for (int k = 0; k < NRand; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      x = {$urandom, $urandom};
      case ($urandom_range(0, 15))
        0:       x = 64'($urandom_range(0, 20));
        1:       x = 64'd0 - 64'($urandom_range(1, 20));
        2:       x = 64'h7FFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      send(x);
    end
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("drain_scoreboard", 64'(sb.size()), 64'd0);
    rand_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
